// File: rtl/pkg_dtypes.sv
// Shared datatypes for the execution-unit datapath and the interconnect
// transmit queue.
package pkg_dtypes;

    typedef logic [31:0] type_exec_unit_data;

    typedef struct packed {
        logic [1:0] eu_idx;
        logic [3:0] reg_idx;
    } type_exec_unit_addr;

    typedef struct packed {
        type_exec_unit_data opd_data;
        type_exec_unit_addr opd_addr;
        logic               opd_opx;
        logic               opd_valid;
    } type_alu_channel_tx;

    typedef struct packed {
        type_exec_unit_addr addr;
        type_exec_unit_data data;
        logic               valid;
    } type_icon_tx_channel;

    typedef struct packed {
        logic success;
    } type_icon_rx_channel;

    typedef struct packed {
        logic               opx;
        type_exec_unit_addr addr;
        type_exec_unit_data data;
    } type_icon_txq_entry;

    localparam int ICON_TXQ_DEPTH = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY  = 2'd0,
        OCC_ACTIVE = 2'd1,
        OCC_FULL   = 2'd2
    } type_txq_occ;

endpackage

// File: rtl/eu_txq_mem.sv
// Entry storage for the interconnect transmit queue: one write port, one
// asynchronous read port, storage intentionally not reset.
module eu_txq_mem
    import pkg_dtypes::*;
#(
    parameter int DEPTH = ICON_TXQ_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  type_icon_txq_entry       i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output type_icon_txq_entry       o_rd_data
);

    type_icon_txq_entry r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/eu_icon_txq.sv
// Outbound write queue from the ALU toward the interconnect, with head retry
// counter. Define EU_TXQ_BYPASS_EN to present a push to an empty queue in the same cycle.
//
// state      | meaning
// OCC_EMPTY  | count == 0, nothing offered (except bypass)
// OCC_ACTIVE | 0 < count < DEPTH, head offered, pushes accepted
// OCC_FULL   | count == DEPTH, head offered, pushes refused
module eu_icon_txq
    import pkg_dtypes::*;
#(
    parameter int DEPTH   = ICON_TXQ_DEPTH,
    parameter int RETRY_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_nreset,
    input  type_alu_channel_tx         i_alu_tx,
    output logic                       o_alu_tx_ready,
    output type_icon_tx_channel        o_icon_tx,
    output logic                       o_icon_opx,
    input  type_icon_rx_channel        i_icon_rx,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [RETRY_W-1:0]         o_retry_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]      C_DEPTH     = CW'(DEPTH);
    localparam logic [RETRY_W-1:0] C_RETRY_MAX = '1;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic [RETRY_W-1:0] r_retry;
    type_txq_occ        r_occ;
    type_txq_occ        w_occ_nxt;

    type_icon_txq_entry w_in_entry;
    type_icon_txq_entry w_head;
    type_icon_txq_entry w_out;
    logic               w_ready;
    logic               w_push;
    logic               w_head_valid;
    logic               w_bypass;
    logic               w_valid;
    logic               w_pop;
    logic               w_deq;
    logic               w_store;

    assign w_in_entry.opx  = i_alu_tx.opd_opx;
    assign w_in_entry.addr = i_alu_tx.opd_addr;
    assign w_in_entry.data = i_alu_tx.opd_data;

    assign w_ready      = (r_occ != OCC_FULL);
    assign w_push       = i_alu_tx.opd_valid && w_ready && i_nreset;
    assign w_head_valid = (r_occ != OCC_EMPTY);

`ifdef EU_TXQ_BYPASS_EN
    assign w_bypass = !w_head_valid && w_push;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry taken in the same cycle never touches storage.
    assign w_valid = w_head_valid || w_bypass;
    assign w_pop   = w_valid && i_icon_rx.success;
    assign w_deq   = w_pop && w_head_valid;
    assign w_store = w_push && !(w_pop && w_bypass);
    assign w_out   = w_bypass ? w_in_entry : w_head;

    eu_txq_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .i_clk    (i_clk),
        .i_wr_en  (w_store),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(w_in_entry),
        .i_rd_addr(r_rd_ptr),
        .o_rd_data(w_head)
    );

    always_comb begin
        w_count_nxt = r_count;
        case ({w_store, w_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        w_occ_nxt = OCC_ACTIVE;
        if (w_count_nxt == '0) begin
            w_occ_nxt = OCC_EMPTY;
        end else if (w_count_nxt == C_DEPTH) begin
            w_occ_nxt = OCC_FULL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_retry  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            if (!w_valid || w_pop) begin
                r_retry <= '0;
            end else if (r_retry != C_RETRY_MAX) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
        end
    end

    always_comb begin
        o_icon_tx  = '0;
        o_icon_opx = 1'b0;
        if (w_valid) begin
            o_icon_tx.valid = 1'b1;
            o_icon_tx.addr  = w_out.addr;
            o_icon_tx.data  = w_out.data;
            o_icon_opx      = w_out.opx;
        end
    end

    assign o_alu_tx_ready = w_ready;
    assign o_count        = r_count;
    assign o_retry_cnt    = r_retry;

endmodule

// File: tb/tb_eu_icon_txq.sv
// Scoreboard bench for eu_icon_txq (default build): expected entries are
// queued at push time and compared by a monitor whenever the head is taken.
module tb_eu_icon_txq;
    import pkg_dtypes::*;

    logic                clk = 1'b0;
    logic                nreset = 1'b0;
    type_alu_channel_tx  alu_tx;
    logic                ready;
    type_icon_tx_channel icon_tx;
    logic                icon_opx;
    type_icon_rx_channel icon_rx;
    logic [2:0]          count;
    logic [7:0]          retry;

    int n_chk = 0;
    int n_pass = 0;
    type_icon_txq_entry exp_q[$];

    always #5 clk = ~clk;

    eu_icon_txq #(
        .DEPTH  (4),
        .RETRY_W(8)
    ) dut (
        .i_clk         (clk),
        .i_nreset      (nreset),
        .i_alu_tx      (alu_tx),
        .o_alu_tx_ready(ready),
        .o_icon_tx     (icon_tx),
        .o_icon_opx    (icon_opx),
        .i_icon_rx     (icon_rx),
        .o_count       (count),
        .o_retry_cnt   (retry)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a push for the coming edge; queue it only if it must be accepted.
    task automatic drive_push(input logic [31:0] d, input logic [1:0] eu, input logic [3:0] rg,
                              input logic o, input bit accept);
        type_icon_txq_entry e;
        alu_tx.opd_valid        = 1'b1;
        alu_tx.opd_data         = d;
        alu_tx.opd_addr.eu_idx  = eu;
        alu_tx.opd_addr.reg_idx = rg;
        alu_tx.opd_opx          = o;
        e.opx          = o;
        e.addr.eu_idx  = eu;
        e.addr.reg_idx = rg;
        e.data         = d;
        if (accept) exp_q.push_back(e);
    endtask

    task automatic idle();
        alu_tx = '0;
    endtask

    // Monitor: every cycle the head is offered and taken, compare it.
    always @(negedge clk) begin
        type_icon_txq_entry got;
        if (nreset && icon_tx.valid && icon_rx.success) begin
            got.opx  = icon_opx;
            got.addr = icon_tx.addr;
            got.data = icon_tx.data;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pop: got 0x%0h expected no entry", got);
            end else begin
                check("pop_entry", got, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_tx  = '0;
        icon_rx = '0;
        // reset, with inputs active to show they are ignored
        alu_tx.opd_valid = 1'b1;
        alu_tx.opd_data  = 32'hDEAD;
        icon_rx.success  = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_valid", icon_tx.valid, 0);
        check("rst_addr", icon_tx.addr, 0);
        check("rst_data", icon_tx.data, 0);
        check("rst_opx", icon_opx, 0);
        check("rst_count", count, 0);
        check("rst_retry", retry, 0);
        check("rst_ready", ready, 1);
        step();
        idle();
        icon_rx = '0;
        nreset  = 1'b1;

        // single push, success tied high
        icon_rx.success = 1'b1;
        drive_push(32'h5A, 2'd1, 4'd3, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_no_comb_path", icon_tx.valid, 0);
        step();
        idle();
        @(negedge clk);
        check("t1_valid", icon_tx.valid, 1);
        check("t1_count1", count, 1);
        step();
        @(negedge clk);
        check("t1_count0", count, 0);
        check("t1_valid0", icon_tx.valid, 0);

        // fill to full, refuse fifth, drain in order
        icon_rx.success = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_push(32'(i), 2'd0, 4'(i), 1'b0, 1'b1);
            step();
        end
        drive_push(32'h5, 2'd0, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_count_full", count, 4);
        check("t2_ready_full", ready, 0);
        step();
        idle();
        @(negedge clk);
        check("t2_refused_count", count, 4);
        check("t2_head_data", icon_tx.data, 1);
        icon_rx.success = 1'b1;
        repeat (4) step();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t2_drained", count, 0);
        check("t2_ready_again", ready, 1);

        // retry saturation
        drive_push(32'hA7, 2'd2, 4'd5, 1'b1, 1'b1);
        step();
        idle();
        @(negedge clk);
        check("t3_retry_start", retry, 0);
        repeat (254) step();
        @(negedge clk);
        check("t3_retry_254", retry, 254);
        step();
        @(negedge clk);
        check("t3_retry_255", retry, 255);
        repeat (50) step();
        @(negedge clk);
        check("t3_retry_sat", retry, 255);
        check("t3_data_held", icon_tx.data, 32'hA7);
        icon_rx.success = 1'b1;
        step();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t3_retry_clr", retry, 0);
        check("t3_count0", count, 0);

        // simultaneous push and pop, mid and full
        drive_push(32'h11, 2'd0, 4'd1, 1'b0, 1'b1);
        step();
        drive_push(32'h12, 2'd0, 4'd2, 1'b0, 1'b1);
        step();
        drive_push(32'h13, 2'd0, 4'd3, 1'b0, 1'b1);
        icon_rx.success = 1'b1;
        step();
        idle();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t4_count_same", count, 2);
        drive_push(32'h14, 2'd0, 4'd4, 1'b0, 1'b1);
        step();
        drive_push(32'h15, 2'd0, 4'd5, 1'b0, 1'b1);
        step();
        drive_push(32'h16, 2'd0, 4'd6, 1'b0, 1'b0);
        icon_rx.success = 1'b1;
        @(negedge clk);
        check("t4_ready_full", ready, 0);
        step();
        idle();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t4_full_pushpop", count, 3);
        icon_rx.success = 1'b1;
        repeat (3) step();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t4_drained", count, 0);

        // reset with a head mid-retry
        drive_push(32'h21, 2'd3, 4'd1, 1'b0, 1'b1);
        step();
        drive_push(32'h22, 2'd3, 4'd2, 1'b0, 1'b1);
        step();
        drive_push(32'h23, 2'd3, 4'd3, 1'b0, 1'b1);
        step();
        idle();
        repeat (5) step();
        @(negedge clk);
        check("t5_count3", count, 3);
        check("t5_retry7", retry, 7);
        nreset = 1'b0;
        drive_push(32'h99, 2'd1, 4'd9, 1'b1, 1'b0);
        icon_rx.success = 1'b1;
        exp_q.delete();
        step();
        nreset = 1'b1;
        idle();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t5_valid0", icon_tx.valid, 0);
        check("t5_count0", count, 0);
        check("t5_ready1", ready, 1);
        check("t5_retry0", retry, 0);
        icon_rx.success = 1'b1;
        repeat (5) step();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t5_still_empty", count, 0);

        // opx follows the head
        drive_push(32'h31, 2'd1, 4'd1, 1'b0, 1'b1);
        step();
        drive_push(32'h32, 2'd1, 4'd2, 1'b1, 1'b1);
        step();
        idle();
        @(negedge clk);
        check("t6_opx_first", icon_opx, 0);
        check("t6_count2", count, 2);
        icon_rx.success = 1'b1;
        step();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t6_opx_second", icon_opx, 1);
        icon_rx.success = 1'b1;
        step();
        icon_rx.success = 1'b0;
        @(negedge clk);
        check("t6_count0", count, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
